// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide sequencer.

package muldiv_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } md_state_t;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } md_op_t;

   function automatic logic is_div(md_op_t op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(md_op_t op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   // MUL low word is sign-agnostic, so it is run as unsigned.
   function automatic logic is_signed_a(md_op_t op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(md_op_t op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the multiply/divide datapath on the {acc, q} register pair:
// shift-add for multiply, restoring trial-subtract for divide.

module muldiv_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] q_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN:0]   addend;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] diff;

   always_comb begin
      addend  = q_i[0] ? {1'b0, b_i} : '0;
      sum     = {1'b0, acc_i} + addend;
      shifted = {acc_i, q_i[XLEN-1]};
      diff    = {1'b0, shifted} - {2'b00, b_i};
      if (is_div_i) begin
         // Borrow out means the trial subtract failed; keep the shifted value.
         if (diff[XLEN+1]) begin
            acc_o = shifted[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b0};
         end else begin
            acc_o = diff[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b1};
         end
      end else begin
         {acc_o, q_o} = {sum, q_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: stalls the pipeline while an iterative unit runs,
// then presents the result on the EX result path for exactly one cycle.

module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MulStartE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic [4:0]      RdE,
   input  logic            FlushMD,
   output logic            StallMD,
   output logic            MDValidE,
   output logic [XLEN-1:0] ResultMD,
   output logic [4:0]      RdMD
);

   localparam int unsigned CNTW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   md_state_t         state_q, state_d;
   md_op_t            op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [4:0]        rd_q, rd_d;

   logic              op_div, sign_a, sign_b, div_zero, div_ovf;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN-1:0]   iter_acc_in, iter_q_in, iter_b_in, iter_acc, iter_q;
   logic [2*XLEN-1:0] prod, prod_s;

   assign op_div   = is_div(op_q);
   assign sign_a   = is_signed_a(op_q) & a_q[XLEN-1];
   assign sign_b   = is_signed_b(op_q) & b_q[XLEN-1];
   assign abs_a    = sign_a ? -a_q : a_q;
   assign abs_b    = sign_b ? -b_q : b_q;
   assign div_zero = op_div && (b_q == '0);
   assign div_ovf  = op_div && is_signed_b(op_q) && (a_q == MinNeg) && (b_q == '1);

   // PREP runs the first iteration straight from the absolute operands.
   assign iter_acc_in = (state_q == PREP) ? '0 : acc_q;
   assign iter_q_in   = (state_q == PREP) ? abs_a : quo_q;
   assign iter_b_in   = (state_q == PREP) ? abs_b : b_q;

   muldiv_iter #(
      .XLEN(XLEN)
   ) u_iter (
      .is_div_i(op_div),
      .acc_i   (iter_acc_in),
      .q_i     (iter_q_in),
      .b_i     (iter_b_in),
      .acc_o   (iter_acc),
      .q_o     (iter_q)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      res_d    = res_q;
      rd_d     = rd_q;
      StallMD  = 1'b0;
      MDValidE = 1'b0;
      prod     = {acc_q, quo_q};
      prod_s   = neg_q ? -prod : prod;

      unique case (state_q)
         IDLE: begin
            if (MulStartE && !FlushMD) begin
               StallMD = 1'b1;
               op_d    = md_op_t'(funct3E);
               a_d     = SrcAE;
               b_d     = SrcBE;
               rd_d    = RdE;
               state_d = PREP;
            end
         end
         PREP: begin
            StallMD = 1'b1;
            cnt_d   = '0;
            b_d     = abs_b;
            neg_d   = is_rem(op_q) ? sign_a : (sign_a ^ sign_b);
            if (div_zero) begin
               res_d   = is_rem(op_q) ? a_q : '1;
               state_d = DONE;
            end else if (div_ovf) begin
               res_d   = is_rem(op_q) ? '0 : MinNeg;
               state_d = DONE;
            end else begin
               acc_d   = iter_acc;
               quo_d   = iter_q;
               state_d = CALC;
            end
         end
         CALC: begin
            StallMD = 1'b1;
            acc_d   = iter_acc;
            quo_d   = iter_q;
            cnt_d   = cnt_q + CNTW'(1);
            if (cnt_d == CNTW'(XLEN-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            StallMD = 1'b1;
            state_d = DONE;
            case (op_q)
               OP_MUL:                       res_d = prod[XLEN-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_s[2*XLEN-1:XLEN];
               OP_DIV, OP_DIVU:              res_d = neg_q ? -quo_q : quo_q;
               default:                      res_d = neg_q ? -acc_q : acc_q;
            endcase
         end
         DONE: begin
            MDValidE = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // An abort drops the op wherever it is; the previous result stays visible.
      if (FlushMD && (state_q != IDLE)) begin
         state_d  = IDLE;
         res_d    = res_q;
         StallMD  = 1'b0;
         MDValidE = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_MUL;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
      end
   end

   assign ResultMD = res_q;
   assign RdMD     = rd_q;

endmodule
